// File: rtl/adaptor_mem_pkg.sv
// Shared types and elaboration helpers for the dual-port tile data memory.
package adaptor_mem_pkg;

   typedef enum logic {ST_INIT, ST_READY} mem_state_t;

   localparam int MIN_READ_LATENCY = 1;
   localparam int MAX_READ_LATENCY = 2;

   function automatic bit read_latency_legal(input int latency);
      return (latency >= MIN_READ_LATENCY) && (latency <= MAX_READ_LATENCY);
   endfunction

   function automatic int byte_lanes(input int data_w);
      return data_w / 8;
   endfunction

endpackage

// File: rtl/adaptor_mem_read_pipe.sv
// Read response delay line: turns an accepted read plus the registered RAM word
// into a readdatavalid pulse and a readdata value that holds between responses.
module adaptor_mem_read_pipe #(
   parameter int LATENCY = 1,
   parameter int DATA_W  = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              accept,
   input  logic [DATA_W-1:0] ram_q,
   output logic [DATA_W-1:0] readdata,
   output logic              readdatavalid
);

   logic [LATENCY-1:0] valid_reg;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_reg <= '0;
      end else begin
         for (int i = LATENCY - 1; i > 0; i--) begin
            valid_reg[i] <= valid_reg[i-1];
         end
         valid_reg[0] <= accept;
      end
   end

   assign readdatavalid = valid_reg[LATENCY-1];

   generate
      if (LATENCY == 1) begin : g_lat1
         // The RAM output register is the only stage; a shadow copy supplies the hold value.
         logic [DATA_W-1:0] hold_reg;

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               hold_reg <= '0;
            end else if (valid_reg[0]) begin
               hold_reg <= ram_q;
            end
         end

         assign readdata = valid_reg[0] ? ram_q : hold_reg;
      end else begin : g_latn
         logic [DATA_W-1:0] data_reg [LATENCY-1];

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               for (int i = 0; i < LATENCY - 1; i++) begin
                  data_reg[i] <= '0;
               end
            end else begin
               if (valid_reg[0]) begin
                  data_reg[0] <= ram_q;
               end
               for (int i = 1; i < LATENCY - 1; i++) begin
                  if (valid_reg[i]) begin
                     data_reg[i] <= data_reg[i-1];
                  end
               end
            end
         end

         assign readdata = data_reg[LATENCY-2];
      end
   endgenerate

endmodule

// File: rtl/adaptor_data_memory_dp.sv
// Dual-port Avalon-MM tile data memory: s1 for the tile processor, s2 for the NoC
// adaptor, with pipelined reads, freeze stall and an optional post-reset clear.
module adaptor_data_memory_dp
   import adaptor_mem_pkg::*;
#(
   parameter int                DATA_W       = 32,
   parameter int                ADDR_W       = 10,
   parameter int                READ_LATENCY = 1,
   parameter int                INIT_CLEAR   = 1,
   parameter logic [DATA_W-1:0] INIT_VALUE   = '0
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   freeze,
   input  logic [ADDR_W-1:0]      s1_address,
   input  logic [DATA_W/8-1:0]    s1_byteenable,
   input  logic                   s1_read,
   input  logic                   s1_write,
   input  logic [DATA_W-1:0]      s1_writedata,
   output logic [DATA_W-1:0]      s1_readdata,
   output logic                   s1_readdatavalid,
   output logic                   s1_waitrequest,
   input  logic [ADDR_W-1:0]      s2_address,
   input  logic [DATA_W/8-1:0]    s2_byteenable,
   input  logic                   s2_read,
   input  logic                   s2_write,
   input  logic [DATA_W-1:0]      s2_writedata,
   output logic [DATA_W-1:0]      s2_readdata,
   output logic                   s2_readdatavalid,
   output logic                   s2_waitrequest,
   output logic                   init_done
);

   localparam int BYTES = byte_lanes(DATA_W);
   localparam int DEPTH = 2 ** ADDR_W;
   // Out-of-range latency settings fall back to a single stage.
   localparam int PIPE_LATENCY = read_latency_legal(READ_LATENCY) ? READ_LATENCY : 1;

   logic [BYTES-1:0][7:0] mem [DEPTH];

   mem_state_t        state_reg;
   logic [ADDR_W-1:0] clr_cnt_reg;
   logic              init_done_reg;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg     <= (INIT_CLEAR != 0) ? ST_INIT : ST_READY;
         clr_cnt_reg   <= '0;
         init_done_reg <= 1'b0;
      end else begin
         case (state_reg)
            ST_INIT: begin
               clr_cnt_reg <= clr_cnt_reg + 1'b1;
               if (clr_cnt_reg == '1) begin
                  state_reg     <= ST_READY;
                  init_done_reg <= 1'b1;
               end
            end
            ST_READY: init_done_reg <= 1'b1;
            default:  state_reg <= ST_READY;
         endcase
      end
   end

   logic clearing;
   logic collision;
   logic s1_wr_acc;
   logic s2_wr_acc;
   logic [1:0] rd_acc;

   assign clearing  = (state_reg == ST_INIT);
   // Same-address writes in one cycle: s1 goes first, s2 retries and lands last.
   assign collision = s1_write & s2_write & (s1_address == s2_address);

   assign s1_waitrequest = ~init_done_reg | freeze;
   assign s2_waitrequest = ~init_done_reg | freeze | collision;

   assign s1_wr_acc = s1_write & ~s1_waitrequest;
   assign s2_wr_acc = s2_write & ~s2_waitrequest;
   assign rd_acc[0] = s1_read & ~s1_write & ~s1_waitrequest;
   assign rd_acc[1] = s2_read & ~s2_write & ~s2_waitrequest;

   logic              a_we;
   logic [ADDR_W-1:0] a_addr;
   logic [BYTES-1:0]  a_be;
   logic [DATA_W-1:0] a_wd;

   // The clear sequencer borrows the s1 write path while waitrequest holds traffic off.
   assign a_we   = clearing | s1_wr_acc;
   assign a_addr = clearing ? clr_cnt_reg : s1_address;
   assign a_be   = clearing ? '1 : s1_byteenable;
   assign a_wd   = clearing ? INIT_VALUE : s1_writedata;

   logic [DATA_W-1:0] ram_q [2];

   always_ff @(posedge clk) begin
      for (int b = 0; b < BYTES; b++) begin
         if (a_we && a_be[b]) begin
            mem[a_addr][b] <= a_wd[b*8 +: 8];
         end
         if (s2_wr_acc && s2_byteenable[b]) begin
            mem[s2_address][b] <= s2_writedata[b*8 +: 8];
         end
      end
      ram_q[0] <= mem[a_addr];
      ram_q[1] <= mem[s2_address];
   end

   logic [DATA_W-1:0] pipe_data [2];
   logic [1:0]        pipe_valid;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_port
         adaptor_mem_read_pipe #(
            .LATENCY (PIPE_LATENCY),
            .DATA_W  (DATA_W)
         ) u_read_pipe (
            .clk           (clk),
            .reset_n       (reset_n),
            .accept        (rd_acc[gi]),
            .ram_q         (ram_q[gi]),
            .readdata      (pipe_data[gi]),
            .readdatavalid (pipe_valid[gi])
         );
      end
   endgenerate

   assign s1_readdata      = pipe_data[0];
   assign s1_readdatavalid = pipe_valid[0];
   assign s2_readdata      = pipe_data[1];
   assign s2_readdatavalid = pipe_valid[1];
   assign init_done        = init_done_reg;

endmodule

// File: tb/tb_adaptor_data_memory_dp.sv
// Directed bench for adaptor_data_memory_dp (16 words, two-cycle read latency, clear on reset).
module tb_adaptor_data_memory_dp;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 4;
   localparam int LAT    = 2;

   logic              clk;
   logic              reset_n;
   logic              freeze;
   logic [ADDR_W-1:0] s1_address, s2_address;
   logic [3:0]        s1_byteenable, s2_byteenable;
   logic              s1_read, s1_write, s2_read, s2_write;
   logic [31:0]       s1_writedata, s2_writedata;
   logic [31:0]       s1_readdata, s2_readdata;
   logic              s1_readdatavalid, s2_readdatavalid;
   logic              s1_waitrequest, s2_waitrequest;
   logic              init_done;

   int n_total = 0;
   int n_bad   = 0;
   int valid_pulses = 0;
   bit watch_valid = 0;

   adaptor_data_memory_dp #(
      .DATA_W       (DATA_W),
      .ADDR_W       (ADDR_W),
      .READ_LATENCY (LAT),
      .INIT_CLEAR   (1),
      .INIT_VALUE   (32'h0)
   ) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .freeze           (freeze),
      .s1_address       (s1_address),
      .s1_byteenable    (s1_byteenable),
      .s1_read          (s1_read),
      .s1_write         (s1_write),
      .s1_writedata     (s1_writedata),
      .s1_readdata      (s1_readdata),
      .s1_readdatavalid (s1_readdatavalid),
      .s1_waitrequest   (s1_waitrequest),
      .s2_address       (s2_address),
      .s2_byteenable    (s2_byteenable),
      .s2_read          (s2_read),
      .s2_write         (s2_write),
      .s2_writedata     (s2_writedata),
      .s2_readdata      (s2_readdata),
      .s2_readdatavalid (s2_readdatavalid),
      .s2_waitrequest   (s2_waitrequest),
      .init_done        (init_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=still_running exp=finished");
      $fatal(1);
   end

   always @(negedge clk) begin
      if (watch_valid && (s1_readdatavalid || s2_readdatavalid)) valid_pulses++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic wait_of(input int port);
      return (port == 1) ? s1_waitrequest : s2_waitrequest;
   endfunction

   function automatic logic valid_of(input int port);
      return (port == 1) ? s1_readdatavalid : s2_readdatavalid;
   endfunction

   task automatic idle_all();
      s1_read = 0; s1_write = 0; s1_address = '0; s1_byteenable = '0; s1_writedata = '0;
      s2_read = 0; s2_write = 0; s2_address = '0; s2_byteenable = '0; s2_writedata = '0;
   endtask

   task automatic wr(input int port, input logic [ADDR_W-1:0] addr, input logic [31:0] data,
                     input logic [3:0] be, input string tag);
      int guard;
      @(negedge clk);
      if (port == 1) begin
         s1_address = addr; s1_writedata = data; s1_byteenable = be; s1_write = 1;
      end else begin
         s2_address = addr; s2_writedata = data; s2_byteenable = be; s2_write = 1;
      end
      #1;
      guard = 0;
      while (wait_of(port) && guard < 20) begin
         @(negedge clk); #1; guard++;
      end
      check({tag, "_acc"}, wait_of(port), 0);
      @(negedge clk);
      s1_write = 0; s2_write = 0;
      $display("write port%0d addr=%0d data=%h be=%b", port, addr, data, be);
   endtask

   task automatic rd(input int port, input logic [ADDR_W-1:0] addr, output logic [31:0] data,
                     input string tag);
      int guard;
      int n;
      @(negedge clk);
      if (port == 1) begin s1_address = addr; s1_read = 1; end
      else begin s2_address = addr; s2_read = 1; end
      #1;
      guard = 0;
      while (wait_of(port) && guard < 20) begin
         @(negedge clk); #1; guard++;
      end
      check({tag, "_acc"}, wait_of(port), 0);
      @(negedge clk);
      s1_read = 0; s2_read = 0;
      n = 1;
      while (!valid_of(port) && n < 8) begin
         @(negedge clk); n++;
      end
      check({tag, "_lat"}, n, LAT);
      data = (port == 1) ? s1_readdata : s2_readdata;
      $display("read port%0d addr=%0d data=%h latency=%0d", port, addr, data, n);
   endtask

   // Called right after reset release: 16 held cycles, then ready on the 16th edge.
   task automatic expect_init(input string tag);
      for (int i = 0; i < 16; i++) begin
         check({tag, "_busy"}, {s1_waitrequest, s2_waitrequest, init_done}, 3'b110);
         @(negedge clk);
      end
      check({tag, "_done"}, init_done, 1);
      check({tag, "_ready"}, {s1_waitrequest, s2_waitrequest}, 2'b00);
      $display("init sequence %s complete", tag);
   endtask

   logic [31:0] d;
   logic [31:0] exp_word [3];

   initial begin
      idle_all();
      freeze  = 0;
      reset_n = 0;

      @(negedge clk);
      check("rst_wait", {s1_waitrequest, s2_waitrequest}, 2'b11);
      check("rst_valid", {s1_readdatavalid, s2_readdatavalid}, 2'b00);
      check("rst_data1", s1_readdata, 32'h0);
      check("rst_data2", s2_readdata, 32'h0);
      check("rst_init_done", init_done, 0);

      @(negedge clk);
      reset_n = 1;
      expect_init("t1");
      rd(1, 4'd7, d, "t1_rd7");
      check("t1_data7", d, 32'h0000_0000);

      wr(1, 4'd3, 32'h1122_3344, 4'b1111, "t2_w0");
      wr(1, 4'd3, 32'hDEAD_BEEF, 4'b0101, "t2_w1");
      rd(1, 4'd3, d, "t2_rd1");
      check("t2_merge_s1", d, 32'h11AD_33EF);
      rd(2, 4'd3, d, "t2_rd2");
      check("t2_merge_s2", d, 32'h11AD_33EF);

      exp_word[0] = 32'hA0A0_0000;
      exp_word[1] = 32'hA1A1_1111;
      exp_word[2] = 32'hA2A2_2222;
      wr(1, 4'd0, exp_word[0], 4'b1111, "t3_w0");
      wr(2, 4'd1, exp_word[1], 4'b1111, "t3_w1");
      wr(1, 4'd2, exp_word[2], 4'b1111, "t3_w2");
      @(negedge clk);
      for (int t = 0; t < 6; t++) begin
         if (t >= 2 && t <= 4) begin
            check("t3_valid", s1_readdatavalid, 1);
            check("t3_data", s1_readdata, exp_word[t-2]);
         end else begin
            check("t3_gap", s1_readdatavalid, 0);
            if (t == 5) check("t3_hold", s1_readdata, exp_word[2]);
         end
         if (t < 3) begin
            s1_read = 1; s1_address = 4'(t);
            check("t3_wait", s1_waitrequest, 0);
         end else begin
            s1_read = 0;
         end
         $display("burst cycle %0d valid=%0b data=%h", t, s1_readdatavalid, s1_readdata);
         @(negedge clk);
      end

      @(negedge clk);
      s1_address = 4'd5; s1_writedata = 32'hAAAA_0000; s1_byteenable = 4'hF; s1_write = 1;
      s2_address = 4'd5; s2_writedata = 32'h0000_BBBB; s2_byteenable = 4'hF; s2_write = 1;
      #1;
      check("t4_s2_stall", s2_waitrequest, 1);
      check("t4_s1_go", s1_waitrequest, 0);
      @(negedge clk);
      s1_write = 0;
      #1;
      check("t4_s2_go", s2_waitrequest, 0);
      @(negedge clk);
      s2_write = 0;
      $display("collision writes issued at addr 5");
      rd(1, 4'd5, d, "t4_rd5");
      check("t4_final", d, 32'h0000_BBBB);

      @(negedge clk);
      s1_address = 4'd6; s1_writedata = 32'h1234_5678; s1_byteenable = 4'hF; s1_write = 1;
      s2_address = 4'd6; s2_read = 1;
      #1;
      check("t4_rdw_nostall", {s1_waitrequest, s2_waitrequest}, 2'b00);
      @(negedge clk);
      s1_write = 0; s2_read = 0;
      @(negedge clk);
      check("t4_rdw_valid", s2_readdatavalid, 1);
      check("t4_rdw_old", s2_readdata, 32'h0);
      $display("cross-port read-during-write addr 6 data=%h", s2_readdata);
      rd(2, 4'd6, d, "t4_rd6");
      check("t4_rdw_new", d, 32'h1234_5678);

      @(negedge clk);
      s1_address = 4'd8; s1_writedata = 32'hCAFE_F00D; s1_byteenable = 4'hF; s1_write = 1;
      @(negedge clk);
      s1_write = 0; s1_read = 1;
      @(negedge clk);
      s1_read = 0;
      @(negedge clk);
      check("t4_wr_rd_valid", s1_readdatavalid, 1);
      check("t4_wr_rd_new", s1_readdata, 32'hCAFE_F00D);
      $display("same-port write-then-read addr 8 data=%h", s1_readdata);

      @(negedge clk);
      s1_address = 4'd1; s1_read = 1;
      @(negedge clk);
      s1_read = 0; freeze = 1; s2_address = 4'd3; s2_read = 1;
      #1;
      check("t5_freeze_w1", {s1_waitrequest, s2_waitrequest}, 2'b11);
      @(negedge clk);
      check("t5_inflight_valid", s1_readdatavalid, 1);
      check("t5_inflight_data", s1_readdata, 32'hA1A1_1111);
      check("t5_freeze_w2", s2_waitrequest, 1);
      check("t5_no_valid", s2_readdatavalid, 0);
      @(negedge clk);
      check("t5_freeze_w3", s2_waitrequest, 1);
      @(negedge clk);
      freeze = 0;
      #1;
      check("t5_release", s2_waitrequest, 0);
      @(negedge clk);
      s2_read = 0;
      check("t5_early", s2_readdatavalid, 0);
      @(negedge clk);
      check("t5_valid", s2_readdatavalid, 1);
      check("t5_data", s2_readdata, 32'h11AD_33EF);
      $display("freeze read addr 3 data=%h", s2_readdata);

      @(negedge clk);
      s1_address = 4'd3; s1_read = 1;
      @(negedge clk);
      s1_read = 0;
      watch_valid = 1;
      reset_n = 0;
      #1;
      check("t6_rst_wait", s1_waitrequest, 1);
      @(negedge clk);
      reset_n = 1;
      for (int i = 0; i < 9; i++) @(negedge clk);
      reset_n = 0;
      #1;
      check("t6_mid_init_done", init_done, 0);
      check("t6_mid_init_wait", s1_waitrequest, 1);
      @(negedge clk);
      reset_n = 1;
      expect_init("t6");
      watch_valid = 0;
      check("t6_no_valid", valid_pulses, 0);
      rd(1, 4'd3, d, "t6_rd3");
      check("t6_cleared", d, 32'h0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
